lsu_mem: RTL
============

# lsu_mem

MEM-stage load/store unit of the pipelined CPU. Consumes the memory-stage copy of the opcode and funct3 forwarded from the EX stage, the ALU result (effective address) and the forwarded rs2 data. It drives a single-outstanding request/ready/rvalid data-memory port and holds the pipeline with `stall_o` until the access completes. It hands aligned, sign/zero-extended load data to the WB stage.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; fixed at 32, other values unsupported

Ports:
- `clk` in 1: system clock
- `rst_n` in 1: reset, synchronous, active-low
- `M_valid` in 1: M stage holds a real instruction (0 = bubble)
- `M_op` in 5: opcode[6:2]; `I1` = load (5'b00000), `S` = store (5'b01000), all others ignored
- `M_f3` in 3: funct3
- `M_alu_out` in 32: effective byte address
- `M_rs2_data` in 32: store source data
- `stall_o` out 1: freeze IF..M stages
- `err_o` out 1: one-cycle pulse on misaligned or illegal-funct3 access
- `dm_req` out 1: memory request
- `dm_we` out 4: byte write strobes; 0000 = read
- `dm_addr` out 32: word address `{addr[31:2],2'b00}`
- `dm_wdata` out 32: lane-replicated store data
- `dm_ready` in 1: request accepted
- `dm_rvalid` in 1: read data valid
- `dm_rdata` in 32: read word
- `W_ld_data` out 32: extracted load result, held until the next load completes

## Operation
- A memory op is `M_valid & (M_op==I1 | M_op==S)`.
- Legal funct3 values:
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
- Misaligned accesses: halfword with `addr[0]=1`; word with `addr[1:0]!=0`.
- FSM states IDLE, REQ, WAIT_R, DONE. All outputs except `stall_o` are registered.
- IDLE:
  - Legal memory op: latch addr, f3, strobes and wdata. Go to REQ.
  - Illegal or misaligned memory op: no request. `err_o`=1 next cycle. State stays IDLE; the instruction retires without memory access.
  - Otherwise stay in IDLE.
- REQ:
  - `dm_req`=1. `dm_addr`, `dm_we` and `dm_wdata` are held stable.
  - On `dm_ready`, `dm_req` drops at the edge. A store goes to DONE; a load goes to WAIT_R.
- WAIT_R:
  - `dm_rvalid` is honoured only in WAIT_R, so the earliest valid data is the cycle after `dm_ready`. A `dm_rvalid` seen in REQ is ignored.
  - On `dm_rvalid`: `W_ld_data` <= extract(`dm_rdata`). Go to DONE.
- DONE: unconditional return to IDLE.
- Store strobes and data:
  - SB: `dm_we` = 0001<<addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: `dm_we` = 0011<<{addr[1],1'b0}; wdata = {2{rs2[15:0]}}.
  - SW: `dm_we` = 1111; wdata = rs2.
- Load extraction: shift = `dm_rdata` >> (8*latched addr[1:0]).
  - LB/LH: sign-extend bit 7 / bit 15 of the shifted word.
  - LBU/LHU: zero-extend.
  - LW: word unchanged.
- `stall_o` = memory op in M & state!=DONE & no error. It is combinational, so the stall starts in the same cycle the op enters M.
- Because the pipeline is stalled, the M-stage inputs are stable while the FSM is busy. The FSM uses only latched copies after IDLE.
- A memory op presented in the cycle after DONE is a new instruction and starts a new access. Back-to-back memory ops are therefore separated by no idle cycle beyond DONE.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State becomes IDLE.
  - `dm_req`, `dm_we`, `dm_addr`, `dm_wdata`, `W_ld_data` and `err_o` become 0.
  - `stall_o` follows its equation; it is forced to 0 while `rst_n`=0.
- Reset mid-access abandons the transaction. `dm_req` is low from the first cycle after the reset edge, and any later `dm_rvalid` is ignored.
- Store with `dm_ready` in its first REQ cycle: stall for 2 cycles (IDLE, REQ); advance in DONE.
- Load with `dm_ready` in its first REQ cycle and `dm_rvalid` one cycle later: stall for 3 cycles. `W_ld_data` is valid from the DONE cycle onward.
- Each wait cycle of `dm_ready` or `dm_rvalid` adds exactly one stall cycle.
- Only one transaction is outstanding; `dm_req` is never asserted in WAIT_R.

## Test plan
- SW, addr 0x104, rs2 0xDEADBEEF, ready immediate:
  - `dm_addr` 0x104, `dm_we` 1111, wdata 0xDEADBEEF.
  - `stall_o` high for 2 cycles.
- SB, addr 0x203, rs2 0x12345678: `dm_we` 1000, wdata 0x78787878, `dm_addr` 0x200.
- LB and LBU, addr 0x302, rdata 0x11F02233, rvalid delayed 3 cycles after ready:
  - LB: `W_ld_data` 0xFFFFFFF0.
  - LBU: `W_ld_data` 0x000000F0.
  - `stall_o` high for 5 cycles.
- LH, addr 0x101 (misaligned): no `dm_req`; `err_o` one-cycle pulse; `stall_o` stays 0; `W_ld_data` unchanged.
- LW with `dm_ready` held low for 4 cycles: `dm_addr` stable throughout; `rst_n` pulled low in cycle 2 -> `dm_req` 0 next cycle; a later rvalid of 0xAAAAAAAA leaves `W_ld_data` at 0.
- Load immediately followed by a dependent store to another word: the second access starts the cycle after DONE and carries the correct strobes.

Source files
------------

// File: rtl/lsu_mem_if.sv
// Data-memory port between the load/store unit (master) and the memory (slave).
// The port allows one outstanding request: request/ready accepts the address
// phase, and rvalid returns read data.
interface lsu_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              dm_req;
  logic [3:0]        dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ready, dm_rvalid, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ready, dm_rvalid, dm_rdata
  );
endinterface

// File: rtl/lsu_mem.sv
// MEM-stage load/store unit. It decodes the M-stage memory op, issues one
// data-memory access, and holds the pipeline until that access completes.
// Load data is aligned and extended before it is handed to WB.
// DATA_W is fixed at 32.
module lsu_mem #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              M_valid,
  input  logic [4:0]        M_op,
  input  logic [2:0]        M_f3,
  input  logic [ADDR_W-1:0] M_alu_out,
  input  logic [DATA_W-1:0] M_rs2_data,
  output logic              stall_o,
  output logic              err_o,
  lsu_mem_if.master         dm,
  output logic [DATA_W-1:0] W_ld_data
);

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t            state_q;
  logic              dm_req_q;
  logic [3:0]        dm_we_q;
  logic [ADDR_W-1:0] dm_addr_q;
  logic [DATA_W-1:0] dm_wdata_q;
  logic [DATA_W-1:0] ld_data_q;
  logic              err_q;
  logic              is_ld_q;
  logic [2:0]        f3_q;
  logic [1:0]        addr_lo_q;

  logic              is_ld_d;
  logic              is_st_d;
  logic              mem_op_d;
  logic              f3_legal_d;
  logic              misal_d;
  logic              bad_d;
  logic [3:0]        we_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] shifted_d;
  logic [DATA_W-1:0] ld_data_d;

  // Decode the live M-stage op: legality, alignment, strobes and replicated store data.
  always_comb begin
    is_ld_d    = M_valid && (M_op == OP_LOAD);
    is_st_d    = M_valid && (M_op == OP_STORE);
    mem_op_d   = is_ld_d || is_st_d;
    f3_legal_d = 1'b0;
    if (is_ld_d) begin
      f3_legal_d = (M_f3 == 3'b000) || (M_f3 == 3'b001) || (M_f3 == 3'b010) ||
                   (M_f3 == 3'b100) || (M_f3 == 3'b101);
    end else if (is_st_d) begin
      f3_legal_d = (M_f3 == 3'b000) || (M_f3 == 3'b001) || (M_f3 == 3'b010);
    end
    // Access size is encoded in funct3[1:0] for both loads and stores.
    unique case (M_f3[1:0])
      2'b01:   misal_d = M_alu_out[0];
      2'b10:   misal_d = (M_alu_out[1:0] != 2'b00);
      default: misal_d = 1'b0;
    endcase
    bad_d = mem_op_d && (!f3_legal_d || misal_d);

    we_d    = 4'b0000;
    wdata_d = M_rs2_data;
    if (is_st_d) begin
      unique case (M_f3[1:0])
        2'b00: begin
          we_d    = 4'b0001 << M_alu_out[1:0];
          wdata_d = {4{M_rs2_data[7:0]}};
        end
        2'b01: begin
          we_d    = 4'b0011 << {M_alu_out[1], 1'b0};
          wdata_d = {2{M_rs2_data[15:0]}};
        end
        default: begin
          we_d    = 4'b1111;
          wdata_d = M_rs2_data;
        end
      endcase
    end
  end

  // Align the returned word using the latched byte offset, then extend it according to the latched funct3.
  always_comb begin
    shifted_d = dm.dm_rdata >> {addr_lo_q, 3'b000};
    unique case (f3_q)
      3'b000:  ld_data_d = {{24{shifted_d[7]}}, shifted_d[7:0]};
      3'b001:  ld_data_d = {{16{shifted_d[15]}}, shifted_d[15:0]};
      3'b100:  ld_data_d = {24'b0, shifted_d[7:0]};
      3'b101:  ld_data_d = {16'b0, shifted_d[15:0]};
      default: ld_data_d = shifted_d;
    endcase
  end

  // Access FSM. All bus and result outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 4'b0000;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      ld_data_q  <= '0;
      err_q      <= 1'b0;
      is_ld_q    <= 1'b0;
      f3_q       <= 3'b000;
      addr_lo_q  <= 2'b00;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mem_op_d) begin
            if (bad_d) begin
              // The faulting instruction retires without a memory access.
              err_q <= 1'b1;
            end else begin
              dm_req_q   <= 1'b1;
              dm_we_q    <= we_d;
              dm_addr_q  <= {M_alu_out[ADDR_W-1:2], 2'b00};
              dm_wdata_q <= wdata_d;
              is_ld_q    <= is_ld_d;
              f3_q       <= M_f3;
              addr_lo_q  <= M_alu_out[1:0];
              state_q    <= REQ;
            end
          end
        end
        REQ: begin
          if (dm.dm_ready) begin
            dm_req_q <= 1'b0;
            state_q  <= is_ld_q ? WAIT_R : DONE;
          end
        end
        WAIT_R: begin
          if (dm.dm_rvalid) begin
            ld_data_q <= ld_data_d;
            state_q   <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall is combinational so it covers the first cycle of the op. It is released in DONE or for a faulting op.
  always_comb begin
    stall_o = rst_n && mem_op_d && (state_q != DONE) && !((state_q == IDLE) && bad_d);
  end

  assign err_o       = err_q;
  assign W_ld_data   = ld_data_q;
  assign dm.dm_req   = dm_req_q;
  assign dm.dm_we    = dm_we_q;
  assign dm.dm_addr  = dm_addr_q;
  assign dm.dm_wdata = dm_wdata_q;

endmodule
